// File: rtl/router_pkg.sv
// Shared definitions for the two-way stream router.
// Optional delivery counters are enabled with ROUTER_COUNT_EN.
package router_pkg;

  localparam logic ROUTE_ONE = 1'b0;
  localparam logic ROUTE_TWO = 1'b1;

  localparam int unsigned COUNT_WIDTH = 16;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/router_out_slice.sv
// One-entry registered output slot of the router.
// The delivery counter exists only when ROUTER_COUNT_EN is defined.
module router_out_slice
  import router_pkg::*;
#(
  parameter int unsigned width = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fill,
  input  logic [width-1:0]       fill_data,
  output logic [width-1:0]       data,
  output logic                   valid,
  input  logic                   ready,
  output logic                   can_accept
`ifdef ROUTER_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] count
`endif
);

  slot_state_t state;

  assign valid = (state == SLOT_FULL);

  // A full slot may take a new word in the same cycle its consumer drains it.
  assign can_accept = (state == SLOT_EMPTY) || ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SLOT_EMPTY;
      data  <= '0;
    end else begin
      case (state)
        SLOT_EMPTY: begin
          if (fill) begin
            state <= SLOT_FULL;
            data  <= fill_data;
          end
        end
        SLOT_FULL: begin
          if (fill) begin
            data <= fill_data;
          end else if (ready) begin
            state <= SLOT_EMPTY;
          end
        end
        default: state <= SLOT_EMPTY;
      endcase
    end
  end

`ifdef ROUTER_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (valid && ready) begin
      count <= count + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/two_way_stream_router.sv
// Routes one valid/ready stream to one of two registered output slots by in_sel.
// Define ROUTER_COUNT_EN to add per-port delivered-word counters.
module two_way_stream_router
  import router_pkg::*;
#(
  parameter int unsigned width = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [width-1:0]       in_data,
  input  logic                   in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [width-1:0]       one_data,
  output logic                   one_valid,
  input  logic                   one_ready,
  output logic [width-1:0]       two_data,
  output logic                   two_valid,
  input  logic                   two_ready
`ifdef ROUTER_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] one_count,
  output logic [COUNT_WIDTH-1:0] two_count
`endif
);

  logic can_one;
  logic can_two;
  logic accept;
  logic fill_one;
  logic fill_two;

  assign in_ready = (in_sel == ROUTE_TWO) ? can_two : can_one;
  assign accept   = in_valid && in_ready;
  assign fill_one = accept && (in_sel == ROUTE_ONE);
  assign fill_two = accept && (in_sel == ROUTE_TWO);

  router_out_slice #(.width(width)) u_one (
    .clk        (clk),
    .reset      (reset),
    .fill       (fill_one),
    .fill_data  (in_data),
    .data       (one_data),
    .valid      (one_valid),
    .ready      (one_ready),
    .can_accept (can_one)
`ifdef ROUTER_COUNT_EN
    ,
    .count      (one_count)
`endif
  );

  router_out_slice #(.width(width)) u_two (
    .clk        (clk),
    .reset      (reset),
    .fill       (fill_two),
    .fill_data  (in_data),
    .data       (two_data),
    .valid      (two_valid),
    .ready      (two_ready),
    .can_accept (can_two)
`ifdef ROUTER_COUNT_EN
    ,
    .count      (two_count)
`endif
  );

endmodule

// File: tb/tb_two_way_stream_router.sv
// Scoreboard bench for two_way_stream_router; counter checks run when ROUTER_COUNT_EN is defined.
module tb_two_way_stream_router;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] one_data;
  logic         one_valid;
  logic         one_ready;
  logic [W-1:0] two_data;
  logic         two_valid;
  logic         two_ready;
`ifdef ROUTER_COUNT_EN
  logic [15:0]  one_count;
  logic [15:0]  two_count;
`endif

  two_way_stream_router #(.width(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .one_data  (one_data),
    .one_valid (one_valid),
    .one_ready (one_ready),
    .two_data  (two_data),
    .two_valid (two_valid),
    .two_ready (two_ready)
`ifdef ROUTER_COUNT_EN
    ,
    .one_count (one_count),
    .two_count (two_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [W-1:0] q_one[$];
  logic [W-1:0] q_two[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Outputs consumed first, then the accepted input is queued (same-port order preserved).
  always @(negedge clk) begin
    if (!reset) begin
      if (one_valid && one_ready) begin
        check("one_has_expected", 32'(q_one.size() != 0), 1);
        if (q_one.size() != 0) check("one_data_order", 32'(one_data), 32'(q_one.pop_front()));
      end
      if (two_valid && two_ready) begin
        check("two_has_expected", 32'(q_two.size() != 0), 1);
        if (q_two.size() != 0) check("two_data_order", 32'(two_data), 32'(q_two.pop_front()));
      end
      if (in_valid && in_ready) begin
        if (in_sel) q_two.push_back(in_data);
        else        q_one.push_back(in_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [W-1:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  task automatic do_reset(input int unsigned cycles);
    reset = 1'b1;
    repeat (cycles) step();
    reset = 1'b0;
    q_one.delete();
    q_two.delete();
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 1'b0, 16'hFFFF);
    one_ready = 1'b1;
    two_ready = 1'b1;

    // Reset with in_valid held high
    repeat (2) step();
    @(negedge clk);
    check("rst_one_valid", 32'(one_valid), 0);
    check("rst_two_valid", 32'(two_valid), 0);
    check("rst_one_data", 32'(one_data), 0);
    check("rst_two_data", 32'(two_data), 0);
    step();
    drive(1'b0, 1'b0, '0);
    reset = 1'b0;
    q_one.delete();
    q_two.delete();
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 1);

    // Single word latency
    step();
    drive(1'b1, 1'b0, 16'h1234);
    @(negedge clk);
    check("lat_in_ready", 32'(in_ready), 1);
    check("lat_one_valid_before", 32'(one_valid), 0);
    step();
    drive(1'b0, 1'b0, '0);
    @(negedge clk);
    check("lat_one_valid", 32'(one_valid), 1);
    check("lat_one_data", 32'(one_data), 32'h1234);
    check("lat_two_valid", 32'(two_valid), 0);
    step();

    // Port two stalled holding 0xBEEF
    two_ready = 1'b0;
    drive(1'b1, 1'b1, 16'hBEEF);
    step();
    drive(1'b1, 1'b1, 16'h0042);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 0);
      check("stall_two_valid", 32'(two_valid), 1);
      check("stall_two_data", 32'(two_data), 32'hBEEF);
      step();
    end
    drive(1'b1, 1'b0, 16'h0042);
    @(negedge clk);
    check("bypass_in_ready", 32'(in_ready), 1);
    step();
    drive(1'b0, 1'b0, '0);
    @(negedge clk);
    check("bypass_one_data", 32'(one_data), 32'h0042);
    check("bypass_two_data", 32'(two_data), 32'hBEEF);
    step();
    two_ready = 1'b1;
    repeat (2) step();

    // Back-to-back alternating ports
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'(i % 2 == 0), 16'(i));
      @(negedge clk);
      check("alt_in_ready", 32'(in_ready), 1);
      step();
    end
    drive(1'b0, 1'b0, '0);
    repeat (2) step();
    check("alt_one_drained", 32'(q_one.size()), 0);
    check("alt_two_drained", 32'(q_two.size()), 0);

    // Drain and refill port one in the same cycle
    one_ready = 1'b0;
    drive(1'b1, 1'b0, 16'h5555);
    step();
    drive(1'b0, 1'b0, '0);
    step();
    one_ready = 1'b1;
    drive(1'b1, 1'b0, 16'hAAAA);
    @(negedge clk);
    check("refill_in_ready", 32'(in_ready), 1);
    check("refill_old_data", 32'(one_data), 32'h5555);
    step();
    drive(1'b0, 1'b0, '0);
    @(negedge clk);
    check("refill_new_valid", 32'(one_valid), 1);
    check("refill_new_data", 32'(one_data), 32'hAAAA);
    step();
    step();

    // Random traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      if (!(in_valid && !in_ready)) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
      one_ready = 1'($urandom_range(0, 3) != 0);
      two_ready = 1'($urandom_range(0, 2) != 0);
      step();
    end
    drive(1'b0, 1'b0, '0);
    one_ready = 1'b1;
    two_ready = 1'b1;
    repeat (3) step();
    check("rand_one_drained", 32'(q_one.size()), 0);
    check("rand_two_drained", 32'(q_two.size()), 0);

    // Reset while both slots hold words
    one_ready = 1'b0;
    two_ready = 1'b0;
    drive(1'b1, 1'b0, 16'h0111);
    step();
    drive(1'b1, 1'b1, 16'h0222);
    step();
    drive(1'b0, 1'b0, '0);
    do_reset(1);
    @(negedge clk);
    check("midrst_one_valid", 32'(one_valid), 0);
    check("midrst_two_valid", 32'(two_valid), 0);
    check("midrst_one_data", 32'(one_data), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
    one_ready = 1'b1;
    two_ready = 1'b1;
    step();

`ifdef ROUTER_COUNT_EN
    do_reset(1);
    drive(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 65537; i++) begin
      in_data = 16'(i);
      step();
    end
    drive(1'b0, 1'b0, '0);
    repeat (2) step();
    @(negedge clk);
    check("cnt_one_wrap", 32'(one_count), 1);
    check("cnt_two_zero", 32'(two_count), 0);
    drive(1'b1, 1'b1, 16'h7777);
    repeat (3) step();
    do_reset(1);
    drive(1'b0, 1'b0, '0);
    @(negedge clk);
    check("cnt_rst_one", 32'(one_count), 0);
    check("cnt_rst_two", 32'(two_count), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
